// File: rtl/gfx_dbuf_swap_ctrl.sv
// gfx_dbuf_swap_ctrl
//   Double-buffer swap controller. A pattern writer fills the back buffer and
//   signals completion with a valid/ready handshake; the controller then waits
//   for the start of the next vertical blank and swaps front/back buffers,
//   so the display never shows a half-written frame.
//
// Parameters
//   SYNC_STAGES  number of vga_vsync synchronizer flops (minimum 2)
//   CNT_WIDTH    width of frame_cnt / skip_cnt (counters wrap)
//
// Ports
//   clk            single clock, all state lives here
//   reset          asynchronous, active-high
//   vga_vsync      active-low display vsync, asynchronous to clk
//   wr_done_valid  writer finished the back buffer (held until accepted)
//   wr_done_ready  controller accepts the done indication (high in WRITE)
//   wr_en          writer may write the back buffer (high in WRITE)
//   disp_sel       front buffer on display: 0 = sram0, 1 = sram1
//   wr_sel         back buffer being written, always ~disp_sel
//   swap_pulse     one-cycle strobe on each swap
//   frame_cnt      number of vblank starts seen
//   skip_cnt       vblank starts with no finished frame (frame repeated)

module gfx_dbuf_swap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_vsync,
    input  logic                 wr_done_valid,
    output logic                 wr_done_ready,
    output logic                 wr_en,
    output logic                 disp_sel,
    output logic                 wr_sel,
    output logic                 swap_pulse,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] skip_cnt
);

    typedef enum logic [1:0] {
        WRITE      = 2'd0,
        WAIT_VSYNC = 2'd1,
        SWAP       = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // vsync synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    // Flops reset to 1 (vsync inactive) so a vsync already low when reset
    // releases yields exactly one vblank_start once it has crossed the chain.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_last_q, sync_last_d;
    logic                   vblank_start;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], vga_vsync};
        sync_last_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            sync_last_q <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            sync_last_q <= sync_last_d;
        end
    end

    // Active-low vsync: vblank begins on the falling edge.
    assign vblank_start = ~sync_q[SYNC_STAGES-1] & sync_last_q;

    // ------------------------------------------------------------------
    // Swap FSM with registered outputs
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   disp_sel_q, disp_sel_d;
    logic   wr_en_q, wr_en_d;
    logic   wr_done_ready_q, wr_done_ready_d;
    logic   swap_pulse_q, swap_pulse_d;
    logic   done_acc;

    assign done_acc = wr_done_valid & wr_done_ready_q;

    always_comb begin
        state_d    = state_q;
        disp_sel_d = disp_sel_q;
        unique case (state_q)
            WRITE: begin
                // A vblank coinciding with acceptance is too early to swap:
                // the frame is only counted as skipped, the swap waits.
                if (done_acc) state_d = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (vblank_start) begin
                    state_d    = SWAP;
                    disp_sel_d = ~disp_sel_q;
                end
            end
            SWAP: begin
                state_d = WRITE;
            end
            default: begin
                state_d = WRITE;
            end
        endcase
        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state they belong to.
        wr_en_d         = (state_d == WRITE);
        wr_done_ready_d = (state_d == WRITE);
        swap_pulse_d    = (state_d == SWAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= WRITE;
            disp_sel_q      <= 1'b0;
            wr_en_q         <= 1'b1;
            wr_done_ready_q <= 1'b1;
            swap_pulse_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            disp_sel_q      <= disp_sel_d;
            wr_en_q         <= wr_en_d;
            wr_done_ready_q <= wr_done_ready_d;
            swap_pulse_q    <= swap_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame / skip counters (wrap naturally at 2^CNT_WIDTH)
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        if (vblank_start) begin
            frame_cnt_d = frame_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            // Still writing when vblank arrives: the old frame is shown again.
            if (state_q == WRITE) begin
                skip_cnt_d = skip_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            skip_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

    assign wr_done_ready = wr_done_ready_q;
    assign wr_en         = wr_en_q;
    assign disp_sel      = disp_sel_q;
    assign wr_sel        = ~disp_sel_q;
    assign swap_pulse    = swap_pulse_q;
    assign frame_cnt     = frame_cnt_q;
    assign skip_cnt      = skip_cnt_q;

endmodule

// File: tb/tb_gfx_dbuf_swap_ctrl.sv
// Testbench for gfx_dbuf_swap_ctrl: directed scenarios plus random vsync /
// writer / reset traffic, checked by a scoreboard against a frame-level model.
// A second instance with CNT_WIDTH=2 shares the stimulus to cover wrap.

module tb_gfx_dbuf_swap_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset, vga_vsync, wr_done_valid;
    logic       wr_done_ready, wr_en, disp_sel, wr_sel, swap_pulse;
    logic [15:0] frame_cnt, skip_cnt;
    logic       b_ready, b_wr_en, b_disp, b_wr_sel, b_swap;
    logic [1:0] b_frame, b_skip;

    always #5 clk = ~clk;

    gfx_dbuf_swap_ctrl #(.SYNC_STAGES(S), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .vga_vsync(vga_vsync),
        .wr_done_valid(wr_done_valid), .wr_done_ready(wr_done_ready),
        .wr_en(wr_en), .disp_sel(disp_sel), .wr_sel(wr_sel),
        .swap_pulse(swap_pulse), .frame_cnt(frame_cnt), .skip_cnt(skip_cnt)
    );

    gfx_dbuf_swap_ctrl #(.SYNC_STAGES(S), .CNT_WIDTH(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .vga_vsync(vga_vsync),
        .wr_done_valid(wr_done_valid), .wr_done_ready(b_ready),
        .wr_en(b_wr_en), .disp_sel(b_disp), .wr_sel(b_wr_sel),
        .swap_pulse(b_swap), .frame_cnt(b_frame), .skip_cnt(b_skip)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        bit disp;
        bit wren;
        bit rdy;
        bit swp;
        int frame;
        int skip;
    } exp_t;

    exp_t expq[$];
    bit   swapq[$];   // expected disp_sel at each swap, in order
    int   vectors = 0;
    int   errors  = 0;
    int   swap_seen = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // The writer/display contract: a finished frame is shown from the first
    // vblank strictly after its done was accepted; the swap cycle is dead time.
    typedef enum {P_WRITE, P_WAIT, P_SWAP} ph_t;
    ph_t m_ph;
    bit  m_disp;
    int  m_frame, m_skip;
    bit  m_acc;
    bit  vh[$];   // vh[i] = vsync value sampled i edges ago

    function automatic void m_reset();
        if (m_ph == P_SWAP && swapq.size() > 0) void'(swapq.pop_back());
        m_ph = P_WRITE; m_disp = 1'b0; m_frame = 0; m_skip = 0; m_acc = 1'b0;
        vh.delete();
        repeat (S + 1) vh.push_back(1'b1);
    endfunction

    function automatic void m_step(input bit vs, input bit dv);
        bit vb;
        // Falling edge becomes visible S edges after it is first sampled.
        vb = !vh[S-1] && vh[S];
        m_acc = dv && (m_ph == P_WRITE);
        if (vb) begin
            m_frame++;
            if (m_ph == P_WRITE) m_skip++;
        end
        case (m_ph)
            P_WRITE: if (m_acc) m_ph = P_WAIT;
            P_WAIT:  if (vb) begin m_ph = P_SWAP; m_disp = !m_disp; swapq.push_back(m_disp); end
            default: m_ph = P_WRITE;
        endcase
        vh.push_front(vs);
        void'(vh.pop_back());
    endfunction

    // One clock of stimulus. Called at posedge+1: the DUT now shows the state
    // after the last edge (or the async reset state), and the inputs set here
    // are sampled at the next edge.
    task automatic cyc(input bit r, input bit vs, input bit dv);
        exp_t e;
        reset = r; vga_vsync = vs; wr_done_valid = dv;
        if (r) m_reset();
        e.disp = m_disp; e.wren = (m_ph == P_WRITE); e.rdy = (m_ph == P_WRITE);
        e.swp = (m_ph == P_SWAP); e.frame = m_frame; e.skip = m_skip;
        expq.push_back(e);
        if (r) m_reset(); else m_step(vs, dv);
        @(posedge clk); #1;
    endtask

    task automatic vs_edge(input bit dv);
        repeat (4) cyc(1'b0, 1'b0, dv);
        repeat (4) cyc(1'b0, 1'b1, dv);
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("disp_sel", disp_sel, mon_e.disp);
            chk("wr_sel", wr_sel, !mon_e.disp);
            chk("wr_en", wr_en, mon_e.wren);
            chk("wr_done_ready", wr_done_ready, mon_e.rdy);
            chk("swap_pulse", swap_pulse, mon_e.swp);
            chk("frame_cnt", frame_cnt, mon_e.frame & 32'hFFFF);
            chk("skip_cnt", skip_cnt, mon_e.skip & 32'hFFFF);
            chk("w2_frame_cnt", b_frame, mon_e.frame & 32'h3);
            chk("w2_skip_cnt", b_skip, mon_e.skip & 32'h3);
        end
        if (swap_pulse) begin
            swap_seen++;
            if (swapq.size() == 0) begin
                vectors++; errors++;
                $display("FAIL swap_event: got unexpected swap_pulse, expected none at %0t", $time);
            end else begin
                chk("swap_disp", disp_sel, swapq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  s0;
        bit  vs, dv, r;
        int  vs_left;
        reset = 1'b1; vga_vsync = 1'b1; wr_done_valid = 1'b0;
        m_ph = P_WRITE;
        m_reset();
        @(posedge clk); #1;
        do_reset();

        // single done then vsync: one swap to sram1
        cyc(1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        vs_edge(1'b0);
        chk("basic_disp", disp_sel, 1); chk("basic_wr_sel", wr_sel, 0);
        chk("basic_wr_en", wr_en, 1);
        chk("basic_frame", frame_cnt, 1); chk("basic_skip", skip_cnt, 0);

        // three vblanks, no frame finished
        do_reset();
        s0 = swap_seen;
        repeat (3) vs_edge(1'b0);
        chk("noframe_disp", disp_sel, 0); chk("noframe_swaps", swap_seen - s0, 0);
        chk("noframe_frame", frame_cnt, 3); chk("noframe_skip", skip_cnt, 3);
        chk("w2_wrap_3", b_frame, 3);
        repeat (2) vs_edge(1'b0);
        chk("w2_wrap_5", b_frame, 1);

        // done accepted in the vblank cycle: swap deferred to the next vblank
        do_reset();
        cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        chk("same_cycle_disp_before", disp_sel, 0);
        vs_edge(1'b0);
        chk("same_cycle_disp", disp_sel, 1);
        chk("same_cycle_frame", frame_cnt, 2); chk("same_cycle_skip", skip_cnt, 1);

        // valid held high across four rounds
        do_reset();
        s0 = swap_seen;
        repeat (4) begin
            cyc(1'b0, 1'b1, 1'b1);
            vs_edge(1'b1);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("held_swaps", swap_seen - s0, 4); chk("held_disp", disp_sel, 0);

        // reset in WAIT_VSYNC abandons the swap
        do_reset();
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rst_wait_disp", disp_sel, 0); chk("rst_wait_wr_en", wr_en, 1);
        cyc(1'b0, 1'b1, 1'b0);
        s0 = swap_seen;
        vs_edge(1'b0);
        chk("rst_wait_swaps", swap_seen - s0, 0); chk("rst_wait_skip", skip_cnt, 1);

        // vsync low across reset release: at most one vblank
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        chk("low_at_reset_frame", frame_cnt, 1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);

        // random traffic
        vs = 1'b1; dv = 1'b0; vs_left = 3;
        for (int i = 0; i < 4000; i++) begin
            if (vs_left == 0) begin vs = !vs; vs_left = $urandom_range(1, 6); end
            else vs_left--;
            if (!dv) dv = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(r, vs, dv);
            if (m_acc || r) dv = 1'b0;
        end
        repeat (3) cyc(1'b0, 1'b1, 1'b0);

        chk("swaps_pending", swapq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
